button_conditioner: RTL and testbench

Input-side companion to the reaction-timer and display logic. It takes raw, asynchronous push-button levels from the board and delivers clean, clock-synchronous signals to the control FSMs. For each button it provides a debounced level plus single-cycle press, release and long-press pulses. Every channel is independent and identical; downstream FSMs consume the pulses instead of raw button levels.

---
 rtl/button_conditioner.sv | 105 ++++++++++
 tb/tb_button_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects raw push buttons.
// Each channel yields a clean level plus press, release and long-press pulses.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LG_LAST = LW'(LONG_CYCLES - 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch

        logic          sync1_q, sync1_d;
        logic          sync2_q, sync2_d;
        logic [DW-1:0] db_cnt_q, db_cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic [LW-1:0] hold_cnt_q, hold_cnt_d;
        logic          fired_q, fired_d;
        logic          long_q, long_d;

        // Synchronize the raw level, then accept a change only after it is stable
        always_comb begin
            sync1_d   = btn_raw[i];
            sync2_d   = sync1_q;
            db_cnt_d  = db_cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sync2_q == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_d   = sync2_q;
                db_cnt_d  = '0;
                press_d   = sync2_q;
                release_d = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end

        // Time a continuous hold; a release on the firing edge suppresses the pulse
        always_comb begin
            hold_cnt_d = hold_cnt_q;
            fired_d    = fired_q;
            long_d     = 1'b0;
            if (!level_q) begin
                hold_cnt_d = '0;
                fired_d    = 1'b0;
            end else if (!fired_q) begin
                if (hold_cnt_q == LG_LAST) begin
                    fired_d = 1'b1;
                    long_d  = ~release_d;
                end else begin
                    hold_cnt_d = hold_cnt_q + LW'(1);
                end
            end
        end

        // Channel state register with synchronous reset
        always_ff @(posedge CLK100MHZ) begin
            if (RST) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                db_cnt_q   <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                hold_cnt_q <= '0;
                fired_q    <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                sync1_q    <= sync1_d;
                sync2_q    <= sync2_d;
                db_cnt_q   <= db_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                hold_cnt_q <= hold_cnt_d;
                fired_q    <= fired_d;
                long_q     <= long_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;

    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scenario tasks with a per-cycle expectation queue.
// Expected outputs come from the documented edge timings, not from a model.
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int DB = 4;
    localparam int LC = 20;

    typedef struct packed {
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] lng;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    button_conditioner #(
        .N_BTN(NB),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES(LC)
    ) dut (
        .CLK100MHZ(clk),
        .RST(rst),
        .btn_raw(raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [1:0] l, input logic [1:0] p,
                                input logic [1:0] r, input logic [1:0] g);
        obs_t o;
        o.lvl = l;
        o.prs = p;
        o.rel = r;
        o.lng = g;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(btn_level, btn_press, btn_release, btn_long);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        raw = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int k = 0; k < 3; k++) begin
            rst = 1'b1;
            raw = 2'b11;
            exp_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00));
            step();
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset k=%0d got=%h want=%h", k, o, e);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        obs_t e, o;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            raw = 2'b01;
            exp_q.push_back(mk({1'b0, k >= 5}, {1'b0, k == 5}, 2'b00, 2'b00));
            step();
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL clean_press k=%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_glitch();
        obs_t e, o;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            raw = {1'b0, k < 3};
            exp_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00));
            step();
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL glitch k=%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_bounce();
        obs_t e, o;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            raw = {1'b0, k != 3};
            exp_q.push_back(mk({1'b0, k >= 9}, {1'b0, k == 9}, 2'b00, 2'b00));
            step();
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL bounce k=%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_long_release();
        obs_t e, o;
        do_reset();
        for (int k = 0; k < 116; k++) begin
            raw = {1'b0, k < 105};
            exp_q.push_back(mk({1'b0, k >= 5 && k < 110}, {1'b0, k == 5},
                               {1'b0, k == 110}, {1'b0, k == 25}));
            step();
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL long_release k=%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_conflict();
        obs_t e, o;
        do_reset();
        for (int k = 0; k < 35; k++) begin
            raw = {1'b0, k < 20};
            exp_q.push_back(mk({1'b0, k >= 5 && k < 25}, {1'b0, k == 5},
                               {1'b0, k == 25}, 2'b00));
            step();
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL conflict k=%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        obs_t e, o;
        do_reset();
        for (int k = 0; k < 46; k++) begin
            raw = 2'b01;
            rst = (k == 15);
            exp_q.push_back(mk({1'b0, (k >= 5 && k < 15) || k >= 21},
                               {1'b0, k == 5 || k == 21},
                               2'b00, {1'b0, k == 41}));
            step();
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid_hold k=%0d got=%h want=%h", k, o, e);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            raw = {k < 12, k < 10};
            exp_q.push_back(mk({k >= 5 && k < 17, k >= 5 && k < 15},
                               {k == 5, k == 5},
                               {k == 17, k == 15}, 2'b00));
            step();
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL back_to_back k=%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_long_release();
        test_conflict();
        test_reset_mid_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
